// File: rtl/operand_entry_ctrl_pkg.sv
// Shared types and constants for the keypad operand entry sequencer.
// Covers state encoding, BCD limits, digit LED codes and a digit-insert helper.
package operand_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;

  localparam logic [2:0] LED_ONES = 3'b001;
  localparam logic [2:0] LED_TENS = 3'b010;
  localparam logic [2:0] LED_HUNS = 3'b100;
  localparam logic [2:0] LED_NONE = 3'b000;

  function automatic logic [11:0] put_digit(
    input logic [11:0] op,
    input logic [1:0]  idx,
    input logic [3:0]  d
  );
    logic [11:0] r;
    r = op;
    case (idx)
      2'd0:    r[3:0]  = d;
      2'd1:    r[7:4]  = d;
      default: r[11:8] = d;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] idx_led(input logic [1:0] idx);
    logic [2:0] r;
    case (idx)
      2'd0:    r = LED_ONES;
      2'd1:    r = LED_TENS;
      default: r = LED_HUNS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_entry_ctrl_key_sync_edge.sv
// Multi-flop synchroniser for a raw key followed by a rising-edge detector.
// rise is a single-cycle pulse per clean press.
module key_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry sequencer: captures three BCD digits plus sign for A
// then B, and offers the pair downstream over a valid/ready handshake.
module operand_entry_ctrl
  import operand_entry_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic        sign_on,
  input  logic [3:0]  bcd_num,
  output logic [11:0] op_a_bcd,
  output logic        op_a_neg,
  output logic [11:0] op_b_bcd,
  output logic        op_b_neg,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [2:0]  digit_leds,
  output logic        operand_sel,
  output logic        digit_err
);

  localparam logic [1:0] IDX_LAST = 2'(DIGITS - 1);

  state_t                 state;
  logic [1:0]             idx;
  logic                   press;
  logic                   clr;
  logic [SYNC_STAGES-1:0] sign_sync;
  logic                   sign_s;

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk  (clk),
    .rst  (rst),
    .key  (key_enter),
    .rise (press)
  );

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk  (clk),
    .rst  (rst),
    .key  (key_clear),
    .rise (clr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_sync <= '0;
    end else begin
      sign_sync <= {sign_sync[SYNC_STAGES-2:0], sign_on};
    end
  end

  assign sign_s = sign_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ENTER_A;
      idx       <= 2'd0;
      op_a_bcd  <= 12'd0;
      op_a_neg  <= 1'b0;
      op_b_bcd  <= 12'd0;
      op_b_neg  <= 1'b0;
      op_valid  <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      digit_err <= 1'b0;
      // clear outranks a coincident press
      if (clr) begin
        idx <= 2'd0;
        case (state)
          ST_ENTER_A: begin
            op_a_bcd <= 12'd0;
            op_a_neg <= 1'b0;
          end
          ST_ENTER_B: begin
            op_b_bcd <= 12'd0;
            op_b_neg <= 1'b0;
          end
          default: begin
            op_a_bcd <= 12'd0;
            op_a_neg <= 1'b0;
            op_b_bcd <= 12'd0;
            op_b_neg <= 1'b0;
            op_valid <= 1'b0;
            state    <= ST_ENTER_A;
          end
        endcase
      end else if (state == ST_PRESENT) begin
        if (op_valid && op_ready) begin
          op_valid <= 1'b0;
          idx      <= 2'd0;
          state    <= ST_ENTER_A;
        end
      end else if (press) begin
        if (bcd_num > BCD_MAX) begin
          digit_err <= 1'b1;
        end else begin
          if (state == ST_ENTER_A) begin
            op_a_bcd <= put_digit(op_a_bcd, idx, bcd_num);
          end else begin
            op_b_bcd <= put_digit(op_b_bcd, idx, bcd_num);
          end
          if (idx == IDX_LAST) begin
            idx <= 2'd0;
            if (state == ST_ENTER_A) begin
              op_a_neg <= sign_s;
              state    <= ST_ENTER_B;
            end else begin
              op_b_neg <= sign_s;
              op_valid <= 1'b1;
              state    <= ST_PRESENT;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
      end
    end
  end

  assign operand_sel = (state == ST_ENTER_B);

  always_comb begin
    digit_leds = idx_led(idx);
    if (state == ST_PRESENT) begin
      digit_leds = LED_NONE;
    end
  end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
Synchronous sequencer for keypad operand entry. Synchronises and edge-detects the raw enter and clear keys, then steps through ones, tens and hundreds digit capture for operand A and then operand B. It validates each digit and latches the sign. It presents the completed signed-BCD operand pair to the downstream arithmetic unit through a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, flops in each key synchroniser (minimum 2)
DIGITS, 3, BCD digits per operand (ones, tens, hundreds); fixed at 3 for this revision

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_enter  input  1  raw enter push-button, asynchronous to clk, active high
key_clear  input  1  raw clear push-button, asynchronous to clk, active high
sign_on  input  1  sign switch; 1 = negative; level, synchronised internally
bcd_num  input  4  digit switches; sampled on the enter-press pulse
op_a_bcd  output  12  operand A as {huns,tens,ones}
op_a_neg  output  1  operand A sign
op_b_bcd  output  12  operand B as {huns,tens,ones}
op_b_neg  output  1  operand B sign
op_valid  output  1  operand pair complete and stable
op_ready  input  1  consumer accepts the pair when op_valid & op_ready
digit_leds  output  3  one-hot digit position awaiting entry: 001 ones, 010 tens, 100 huns; 000 in PRESENT
operand_sel  output  1  0 = entering A, 1 = entering B
digit_err  output  1  one-cycle pulse when a press carries bcd_num > 9

Behaviour:
- Reset is asynchronous and active-high. While rst is asserted:
  - op_a_bcd, op_b_bcd = 0; op_a_neg, op_b_neg = 0.
  - op_valid = 0; digit_err = 0; operand_sel = 0.
  - digit_leds = 001; state = ENTER_A; digit index = 0.
  - Synchroniser flops are cleared to 0.
- Key conditioning:
  - key_enter, key_clear and sign_on each pass through SYNC_STAGES flops.
  - press = synced enter & ~previous synced enter. This is a one-cycle pulse per rising edge.
  - clr = rising edge of synced clear, detected the same way.
  - Debounce is out of scope; the board supplies clean keys.
- States: ENTER_A, ENTER_B, PRESENT. The 2-bit digit index idx runs 0..2.
- ENTER_A / ENTER_B on press:
  - If bcd_num <= 9: write bcd_num into digit idx of the active operand.
    - idx 0 → [3:0], idx 1 → [7:4], idx 2 → [11:8].
    - If idx < 2: idx increments.
    - If idx == 2: the active operand's neg bit takes synced sign_on that cycle, and idx returns to 0.
      - From ENTER_A the state moves to ENTER_B.
      - From ENTER_B the state moves to PRESENT.
  - If bcd_num > 9: no register changes, idx holds, and digit_err pulses in the next cycle (registered).
- Digit writes are visible on op_*_bcd the cycle after the press.
- Entering a new operand does not pre-clear it. Digits not yet rewritten keep their old values until overwritten.
- clr in ENTER_A or ENTER_B:
  - Zero the active operand's bcd and neg bits and set idx = 0.
  - The state is unchanged; the other operand is untouched.
- clr in PRESENT: op_valid drops, both operands are zeroed, and the state goes to ENTER_A.
- Simultaneous clr and press: clr wins and the press is discarded.
- PRESENT:
  - op_valid = 1 (registered; asserted the cycle the state enters PRESENT).
  - op_a/op_b are held stable while op_valid is high.
  - press is ignored here; no digit_err is raised.
  - Handshake: when op_valid & op_ready are sampled high, the next state is ENTER_A and op_valid = 0 in the following cycle. Operand values are retained for display.
  - op_ready high with op_valid low has no effect.
- Latency: the third digit of B is pressed at cycle n → op_valid = 1 at n+1. Minimum raw-edge-to-press delay is SYNC_STAGES+1 cycles.
- Outputs digit_leds and operand_sel decode directly from the state and idx registers (registered state, no raw-input paths).
- Reset mid-entry or mid-handshake returns every output to its reset value immediately. No partial operand survives.

Decomposition:
- Shared package/include file holds:
  - State encoding constants ST_ENTER_A = 2'd0, ST_ENTER_B = 2'd1, ST_PRESENT = 2'd2.
  - BCD_MAX = 4'd9.
  - Digit-LED one-hot constants.
- One sub-module, key_sync_edge (parameter SYNC_STAGES), instantiated twice: for enter (press) and for clear (clr).
- sign_on uses a plain synchroniser inside the top level.

Test Plan:
- Reset then presses 3,4,5 (sign 0) then 1,0,9 (sign 1) → op_a_bcd = 12'h543, op_a_neg = 0, op_b_bcd = 12'h901, op_b_neg = 1, op_valid = 1 one cycle after the sixth press; digit_leds steps 001→010→100→001→010→100→000.
- Press with bcd_num = 4'hC at idx 1 → digit_err pulses one cycle, digit_leds stays 010, op_a_bcd unchanged; a following press of 7 writes tens = 7.
- PRESENT with op_ready = 0 for 5 cycles, then 1 for one cycle → op_valid high throughout the wait, low the cycle after the handshake, state = ENTER_A, operands retained; presses during the wait change nothing.
- After two digits of B, assert clear with a simultaneous press → op_b_bcd = 0, op_b_neg = 0, digit_leds = 001, operand_sel = 1, op_a unchanged, press discarded.
- Assert rst asynchronously mid-entry of B (between clock edges) → all outputs reach reset values without waiting for clk; the first press after release writes A ones.
- key_enter held high for 20 cycles → exactly one digit captured.
